// File: rtl/ps2_ascii_fifo.sv
// ps2_ascii_fifo
//   Captures 7-bit key codes from an upstream PS/2 decoder into a small
//   show-ahead FIFO. A two-state capture FSM (IDLE/ACK) acknowledges each
//   code with a registered one-cycle rx_ascii_read pulse. A key that arrives
//   while the FIFO cannot accept it is still acknowledged, but it is dropped.
//
// Optional feature: define PS2_ASCII_FIFO_OVF_EN to build in the sticky
//   overflow flag and its clr_ovf clear. Without the macro, overflow is tied
//   to 0 and clr_ovf is ignored.
//
// Ports:
//   clk              clock; all state changes on its rising edge
//   rstn             asynchronous active-low reset
//   ascii_code       [6:0] key code from upstream
//   ascii_data_ready upstream holds a new, unread code
//   rx_ascii_read    registered one-cycle acknowledge to upstream
//   pop              consumer removes the head entry (ignored when empty)
//   rd_data          [6:0] head entry, show-ahead; 0 while empty
//   empty / full     FIFO status
//   count            [DEPTH_LOG2:0] number of entries held
//   overflow         sticky flag for a dropped key
//   clr_ovf          clears overflow on the next edge
//   dbg_state_o      capture FSM state (0 = IDLE, 1 = ACK)
//
// Handshakes:
//   Upstream holds ascii_data_ready with a stable ascii_code. The block takes
//   the code in an IDLE cycle and raises rx_ascii_read for exactly the next
//   cycle, which is the ACK cycle. It ignores ascii_data_ready during ACK.
//   The consumer asserts pop for one cycle per entry it has taken from
//   rd_data; a pop while empty=1 has no effect.
module ps2_ascii_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [6:0]            ascii_code,
  input  logic                  ascii_data_ready,
  output logic                  rx_ascii_read,
  input  logic                  pop,
  output logic [6:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic                  dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                state_q;
  logic                  rx_read_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [6:0]            mem_q [DEPTH];

  logic capture;
  logic writable;
  logic do_push;
  logic do_pop;
  logic drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop in the same cycle frees a slot even when full. The pop is then
  // valid, because a full FIFO is never empty.
  assign capture  = (state_q == IDLE) && ascii_data_ready;
  assign writable = !full || pop;
  assign do_push  = capture && writable;
  assign drop     = capture && !writable;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Capture FSM with registered acknowledge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rx_read_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ascii_data_ready) begin
            state_q   <= ACK;
            rx_read_q <= 1'b1;
          end else begin
            rx_read_q <= 1'b0;
          end
        end
        ACK: begin
          state_q   <= IDLE;
          rx_read_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          rx_read_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset. Stale contents stay hidden because rd_data is
  // masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= ascii_code;
  end

  assign rd_data       = empty ? 7'h00 : mem_q[rd_ptr_q];
  assign rx_ascii_read = rx_read_q;
  assign count         = count_q;
  assign dbg_state_o   = state_q;

`ifdef PS2_ASCII_FIFO_OVF_EN
  logic overflow_q;

  // A drop in the same cycle wins over the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;
`else
  logic unused_ovf;

  assign unused_ovf = clr_ovf ^ drop;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// Testbench for ps2_ascii_fifo with a four-entry FIFO (DEPTH_LOG2=2).
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// at that point as well, which is away from the active clock edge.
module tb_ps2_ascii_fifo;

  localparam int DL = 2;

`ifdef PS2_ASCII_FIFO_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic [6:0]    ascii_code;
  logic          ascii_data_ready;
  logic          rx_ascii_read;
  logic          pop;
  logic [6:0]    rd_data;
  logic          empty;
  logic          full;
  logic [DL:0]   count;
  logic          overflow;
  logic          clr_ovf;
  logic          dbg_state;

  int n_checks;
  int n_errors;

  ps2_ascii_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .ascii_code       (ascii_code),
    .ascii_data_ready (ascii_data_ready),
    .rx_ascii_read    (rx_ascii_read),
    .pop              (pop),
    .rd_data          (rd_data),
    .empty            (empty),
    .full             (full),
    .count            (count),
    .overflow         (overflow),
    .clr_ovf          (clr_ovf),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one key for a single capture edge, then let the ACK cycle pass.
  task automatic push_key(input logic [6:0] c);
    ascii_code       = c;
    ascii_data_ready = 1'b1;
    step();
    ascii_data_ready = 1'b0;
    step();
  endtask

  task automatic pop_one();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];

  task automatic pop_and_check(input string tag);
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'(empty), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(rd_data), 32'(e));
    end
    pop_one();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rx"},    32'(rx_ascii_read), 32'd0);
    check_eq({tag, "_count"}, 32'(count),         32'd0);
    check_eq({tag, "_empty"}, 32'(empty),         32'd1);
    check_eq({tag, "_full"},  32'(full),          32'd0);
    check_eq({tag, "_rd"},    32'(rd_data),       32'd0);
    check_eq({tag, "_ovf"},   32'(overflow),      32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state),     32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    ascii_code = 7'h00;
    ascii_data_ready = 1'b0;
    pop = 1'b0;
    clr_ovf = 1'b0;
    #12;
    check_reset_outputs("reset");
    rstn = 1'b1;
    step();

    // Hold ready for 2 cycles: one capture, one ACK pulse.
    ascii_code = 7'h41;
    ascii_data_ready = 1'b1;
    step();
    check_eq("k41_rx_hi",  32'(rx_ascii_read), 32'd1);
    check_eq("k41_state",  32'(dbg_state),     32'd1);
    check_eq("k41_count",  32'(count),         32'd1);
    check_eq("k41_rd",     32'(rd_data),       32'h41);
    check_eq("k41_empty",  32'(empty),         32'd0);
    step();
    ascii_data_ready = 1'b0;
    check_eq("k41_rx_lo",  32'(rx_ascii_read), 32'd0);
    check_eq("k41_count2", 32'(count),         32'd1);
    pop_one();
    check_eq("k41_popped", 32'(empty), 32'd1);

    // Three keys popped on consecutive cycles, then a pop while empty.
    push_key(7'h31);
    push_key(7'h32);
    push_key(7'h33);
    check_eq("seq_count3", 32'(count), 32'd3);
    pop = 1'b1;
    check_eq("seq_rd31", 32'(rd_data), 32'h31);
    step();
    check_eq("seq_rd32", 32'(rd_data), 32'h32);
    step();
    check_eq("seq_rd33", 32'(rd_data), 32'h33);
    step();
    check_eq("seq_rd0",    32'(rd_data), 32'h00);
    check_eq("seq_empty",  32'(empty),   32'd1);
    step();
    pop = 1'b0;
    check_eq("seq_pop4_count", 32'(count),   32'd0);
    check_eq("seq_pop4_empty", 32'(empty),   32'd1);
    check_eq("seq_pop4_rd",    32'(rd_data), 32'h00);

    // Fill to 4 entries; the 5th key is acknowledged and dropped. It arrives
    // together with clr_ovf, and the drop must win over the clear.
    for (int i = 0; i < 4; i++) begin
      push_key(7'h61 + 7'(i));
      exp_q.push_back(7'h61 + 7'(i));
    end
    check_eq("full_flag",  32'(full),  32'd1);
    check_eq("full_count", 32'(count), 32'd4);
    ascii_code = 7'h65;
    ascii_data_ready = 1'b1;
    clr_ovf = 1'b1;
    step();
    ascii_data_ready = 1'b0;
    clr_ovf = 1'b0;
    check_eq("drop_rx",    32'(rx_ascii_read), 32'd1);
    check_eq("drop_count", 32'(count),         32'd4);
    check_eq("drop_ovf",   32'(overflow),      32'(OVF_EXP));
    step();
    for (int i = 0; i < 4; i++) pop_and_check("drop_pop");
    check_eq("drop_drained", 32'(empty), 32'd1);
    check_eq("ovf_sticky",   32'(overflow), 32'(OVF_EXP));
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO, with a capture and a pop in the same cycle.
    for (int i = 0; i < 4; i++) begin
      push_key(7'h71 + 7'(i));
      exp_q.push_back(7'h71 + 7'(i));
    end
    ascii_code = 7'h7A;
    ascii_data_ready = 1'b1;
    pop = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(7'h7A);
    step();
    ascii_data_ready = 1'b0;
    pop = 1'b0;
    check_eq("pp_count", 32'(count),    32'd4);
    check_eq("pp_ovf",   32'(overflow), 32'd0);
    check_eq("pp_head",  32'(rd_data),  32'h72);
    step();
    for (int i = 0; i < 4; i++) pop_and_check("pp_pop");
    check_eq("pp_empty", 32'(empty), 32'd1);

    // Pointer wrap: alternating push/pop over 10 values.
    for (int i = 1; i <= 10; i++) begin
      push_key(7'(i));
      check_eq("wrap_count", 32'(count),   32'd1);
      check_eq("wrap_rd",    32'(rd_data), 32'(i));
      pop_one();
      check_eq("wrap_empty", 32'(empty),   32'd1);
    end

    // Reset asserted during ACK with 2 entries held plus one just captured.
    push_key(7'h11);
    push_key(7'h12);
    ascii_code = 7'h13;
    ascii_data_ready = 1'b1;
    step();
    ascii_data_ready = 1'b0;
    check_eq("mid_ack_state", 32'(dbg_state), 32'd1);
    check_eq("mid_ack_count", 32'(count),     32'd3);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    #2;
    rstn = 1'b1;
    step();
    push_key(7'h20);
    check_eq("post_rst_count", 32'(count),   32'd1);
    check_eq("post_rst_rd",    32'(rd_data), 32'h20);
    pop_one();
    check_eq("post_rst_empty", 32'(empty),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_fifo.md
PS2_ASCII_FIFO -- requirements
Module: ps2_ascii_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 entries of 7 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port ascii_code, input, 7 bits: key code from the upstream PS/2 decoder.
REQ-005 The block SHALL have port ascii_data_ready, input, 1 bit: upstream holds a new, unread code.
REQ-006 The block SHALL have port rx_ascii_read, output, 1 bit: registered one-cycle acknowledge to upstream.
REQ-007 The block SHALL have port pop, input, 1 bit: consumer removes the head entry.
REQ-008 The block SHALL have port rd_data, output, 7 bits: show-ahead head entry; 0 when empty.
REQ-009 The block SHALL have port empty, output, 1 bit: FIFO empty.
REQ-010 The block SHALL have port full, output, 1 bit: FIFO full.
REQ-011 The block SHALL have port count, output, DEPTH_LOG2+1 bits: entries held.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky dropped-key flag.
REQ-013 The block SHALL have port clr_ovf, input, 1 bit: clears overflow.

Function
REQ-014 Capture FSM SHALL have two states: IDLE and ACK.
REQ-015 In IDLE with ascii_data_ready=1, the block SHALL write ascii_code (if writable per REQ-019), set rx_ascii_read=1 for the next cycle, and go to ACK.
REQ-016 ACK SHALL last exactly one cycle: rx_ascii_read=1, no capture regardless of ascii_data_ready, then return to IDLE.
REQ-017 A code re-asserted by upstream in the cycle after ACK SHALL be captured as a new key, giving back-to-back capture every 2 cycles.
REQ-018 A captured code SHALL appear on rd_data, with count incremented and empty deasserted, in the cycle after capture; total latency from ascii_data_ready to visibility is one edge.
REQ-019 The FIFO is writable when full=0 or pop=1 in the same cycle; simultaneous push and pop SHALL leave count unchanged and order preserved.
REQ-020 pop with empty=1 SHALL be ignored: no pointer, count or flag change.
REQ-021 A capture when not writable SHALL drop the code, still acknowledge upstream, and set overflow.
REQ-022 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap from 2**DEPTH_LOG2-1 to 0; full = count==2**DEPTH_LOG2, empty = count==0.
REQ-023 clr_ovf SHALL clear overflow on the next edge; a same-cycle drop SHALL take priority and leave overflow=1.

Reset
REQ-024 rstn=0 SHALL immediately force: FSM IDLE, pointers 0, count 0, empty=1, full=0, rd_data 0, rx_ascii_read 0, overflow 0.
REQ-025 Reset mid-ACK or with data held SHALL discard all contents; after release the first ascii_data_ready=1 SHALL be treated as a new key.
REQ-026 Storage array contents need not be reset; rd_data SHALL be masked to 0 while empty=1.

Configuration
REQ-027 With macro PS2_ASCII_FIFO_OVF_EN defined, REQ-021 and REQ-023 overflow tracking SHALL be built in.
REQ-028 Without PS2_ASCII_FIFO_OVF_EN, overflow SHALL be tied 0 and clr_ovf ignored; dropping and acknowledging on full SHALL be unchanged.

Verification
REQ-029 Reset, then ascii_data_ready=1 with ascii_code=7'h41 for 2 cycles -> exactly one rx_ascii_read pulse, count=1, rd_data=7'h41, empty=0.
REQ-030 Push 7'h31,7'h32,7'h33, then pop three consecutive cycles -> rd_data sequence 31,32,33, then 0 with empty=1; a 4th pop changes nothing.
REQ-031 DEPTH_LOG2=2: push 5 keys 7'h61..7'h65 -> full=1 after 4, 5th acknowledged and dropped, overflow=1 (macro on) / 0 (macro off), pops return 61..64.
REQ-032 Full FIFO with pop=1 in the same cycle as a capture of 7'h7A -> count stays 4, 7'h7A is read last, overflow stays 0.
REQ-033 Pointer wrap: DEPTH_LOG2=2, 10 alternating push/pop pairs of 7'h01..7'h0A -> each value read in order, count never exceeds 1.
REQ-034 rstn pulsed low during ACK with 2 entries held -> outputs per REQ-024 immediately; next key 7'h20 is captured as the sole entry.
